// File: rtl/encode_ctl.sv
// Job controller for the LZF encode datapath: sequences a job from start through
// last-byte, pipeline drain and completion, with stall timeout and abort.
module encode_ctl #(
    parameter int unsigned LZF_WIDTH = 20,
    parameter logic [15:0] TIMEOUT   = 16'hFFFF,
    parameter int unsigned DRAIN_CYC = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [LZF_WIDTH-1:0] src_len,
    input  logic                 data_valid,
    input  logic                 data_empty,
    output logic                 ce,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LZF_WIDTH-1:0] byte_cnt
);

    localparam int unsigned STALL_W = 16;
    localparam int unsigned DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LAST,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_t;

    state_t               state, state_nxt;
    logic [LZF_WIDTH-1:0] len_q, len_nxt;
    logic [LZF_WIDTH-1:0] cnt_nxt;
    logic [STALL_W-1:0]   stall_q, stall_nxt, stall_inc;
    logic [DRAIN_W-1:0]   drain_q, drain_nxt;
    logic                 err_nxt;
    logic                 timeout_hit;

    // Timeout fires on the stall cycle that brings the counter to TIMEOUT.
    assign stall_inc   = (stall_q == TIMEOUT) ? stall_q : stall_q + STALL_W'(1);
    assign timeout_hit = !data_valid && (stall_q >= TIMEOUT - STALL_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            len_q    <= '0;
            stall_q  <= '0;
            drain_q  <= '0;
            byte_cnt <= '0;
            err      <= 1'b0;
            ce       <= 1'b0;
            m_last   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            len_q    <= len_nxt;
            stall_q  <= stall_nxt;
            drain_q  <= drain_nxt;
            byte_cnt <= cnt_nxt;
            err      <= err_nxt;
            ce       <= state_nxt inside {S_RUN, S_LAST, S_DRAIN};
            m_last   <= state_nxt inside {S_LAST, S_DRAIN};
            busy     <= state_nxt != S_IDLE;
            done     <= state_nxt inside {S_DONE, S_ERR};
        end
    end

    always_comb begin
        state_nxt = state;
        len_nxt   = len_q;
        cnt_nxt   = byte_cnt;
        stall_nxt = stall_q;
        drain_nxt = drain_q;
        err_nxt   = err;

        case (state)
            S_IDLE: begin
                stall_nxt = '0;
                drain_nxt = '0;
                if (start) begin
                    cnt_nxt = '0;
                    err_nxt = 1'b0;
                    len_nxt = src_len;
                    if (src_len == '0)
                        state_nxt = S_DONE;
                    else if (src_len == LZF_WIDTH'(1))
                        state_nxt = S_LAST;
                    else
                        state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (data_valid) begin
                    cnt_nxt   = byte_cnt + LZF_WIDTH'(1);
                    stall_nxt = '0;
                    if (byte_cnt == len_q - LZF_WIDTH'(2))
                        state_nxt = S_LAST;
                end else begin
                    stall_nxt = stall_inc;
                    if (timeout_hit) begin
                        state_nxt = S_ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            S_LAST: begin
                if (data_valid) begin
                    cnt_nxt   = byte_cnt + LZF_WIDTH'(1);
                    stall_nxt = '0;
                end else begin
                    stall_nxt = stall_inc;
                end
                // A completed datapath takes precedence over a coincident timeout.
                if (data_empty) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = '0;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                    err_nxt   = 1'b1;
                end
            end
            S_DRAIN: begin
                stall_nxt = '0;
                if (data_valid)
                    cnt_nxt = byte_cnt + LZF_WIDTH'(1);
                drain_nxt = drain_q + DRAIN_W'(1);
                if (drain_q == DRAIN_END)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // Abort overrides every other event and leaves count and error untouched.
        if (abort && (state != S_IDLE)) begin
            state_nxt = S_IDLE;
            len_nxt   = len_q;
            cnt_nxt   = byte_cnt;
            stall_nxt = '0;
            drain_nxt = '0;
            err_nxt   = err;
        end
    end

endmodule

// File: tb/tb_encode_ctl.sv
// Bench for encode_ctl: directed job scenarios plus randomized jobs checked every
// cycle against a job-level reference model.
module tb_encode_ctl;

    localparam int unsigned W   = 20;
    localparam int unsigned TMO = 16;
    localparam int unsigned DRN = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic         abort;
    logic [W-1:0] src_len;
    logic         data_valid;
    logic         data_empty;
    logic         ce;
    logic         m_last;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] byte_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: job-level view (bytes remaining, drain countdown, stall time).
    bit           e_busy, e_ce, e_last, e_done, e_err, closing;
    logic [W-1:0] e_cnt, e_len;
    int           stall, drain_left;

    encode_ctl #(
        .LZF_WIDTH(W),
        .TIMEOUT  (16'(TMO)),
        .DRAIN_CYC(DRN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .src_len   (src_len),
        .data_valid(data_valid),
        .data_empty(data_empty),
        .ce        (ce),
        .m_last    (m_last),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .byte_cnt  (byte_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("ce",       32'(ce),       32'(e_ce));
        check("m_last",   32'(m_last),   32'(e_last));
        check("busy",     32'(busy),     32'(e_busy));
        check("done",     32'(done),     32'(e_done));
        check("err",      32'(err),      32'(e_err));
        check("byte_cnt", 32'(byte_cnt), 32'(e_cnt));
    endtask

    task automatic model_reset();
        e_busy = 0; e_ce = 0; e_last = 0; e_done = 0; e_err = 0; closing = 0;
        e_cnt = '0; e_len = '0; stall = 0; drain_left = 0;
    endtask

    task automatic finish_job(input bit timed_out);
        e_ce    = 0;
        e_last  = 0;
        e_done  = 1;
        closing = 1;
        if (timed_out) e_err = 1;
    endtask

    task automatic model_step();
        if (!e_busy) begin
            e_done = 0;
            if (start) begin
                e_cnt = '0; e_err = 0; e_len = src_len; stall = 0; drain_left = 0;
                e_busy = 1;
                if (src_len == '0) begin
                    closing = 1;
                    e_done  = 1;
                end else begin
                    e_ce   = 1;
                    e_last = (src_len == W'(1));
                end
            end
        end else if (abort) begin
            e_busy = 0; e_ce = 0; e_last = 0; e_done = 0; closing = 0; drain_left = 0;
        end else if (closing) begin
            e_busy = 0; e_done = 0; closing = 0;
        end else if (drain_left > 0) begin
            if (data_valid) e_cnt = e_cnt + 1'b1;
            drain_left--;
            if (drain_left == 0) finish_job(0);
        end else begin
            bit was_last;
            was_last = e_last;
            if (data_valid) begin
                e_cnt = e_cnt + 1'b1;
                stall = 0;
                if (!was_last && (e_len - e_cnt == W'(1))) e_last = 1;
            end else begin
                stall++;
            end
            if (was_last && data_empty)
                drain_left = DRN;
            else if (!data_valid && stall >= TMO)
                finish_job(1);
        end
    endtask

    task automatic tick(input bit s, input bit a, input bit dv, input bit de, input logic [W-1:0] len);
        start = s; abort = a; data_valid = dv; data_empty = de; src_len = len;
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    initial begin
        rst = 1'b0; start = 0; abort = 0; data_valid = 0; data_empty = 0; src_len = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Normal 8-byte job with continuous data.
        tick(1, 0, 0, 0, W'(8));
        check("a_ce_rise", 32'(ce), 32'd1);
        check("a_last_low", 32'(m_last), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            tick(0, 0, 1, 0, '0);
            if (i == 6) check("a_last_before7", 32'(m_last), 32'd0);
            if (i == 7) check("a_last_after7", 32'(m_last), 32'd1);
        end
        tick(0, 0, 0, 0, '0);
        tick(0, 0, 0, 1, '0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 0, '0);
            check("a_done_early", 32'(done), 32'd0);
        end
        tick(0, 0, 0, 0, '0);
        check("a_done", 32'(done), 32'd1);
        check("a_cnt8", 32'(byte_cnt), 32'd8);
        check("a_ce_off", 32'(ce), 32'd0);
        tick(0, 0, 0, 0, '0);
        check("a_idle", 32'(busy), 32'd0);
        check("a_cnt_hold", 32'(byte_cnt), 32'd8);

        // Zero-length job completes immediately without chip enable.
        tick(1, 0, 0, 0, '0);
        check("b_done", 32'(done), 32'd1);
        check("b_ce", 32'(ce), 32'd0);
        check("b_cnt", 32'(byte_cnt), 32'd0);
        tick(0, 0, 1, 1, '0);
        check("b_done_off", 32'(done), 32'd0);

        // Stall after two bytes leads to timeout error.
        tick(1, 0, 0, 0, W'(4));
        tick(0, 0, 1, 0, '0);
        tick(0, 0, 1, 0, '0);
        for (int i = 1; i <= 15; i++) tick(0, 0, 0, 0, '0);
        check("c_no_err_yet", 32'(err), 32'd0);
        check("c_ce_still", 32'(ce), 32'd1);
        tick(0, 0, 0, 0, '0);
        check("c_err", 32'(err), 32'd1);
        check("c_done", 32'(done), 32'd1);
        check("c_ce_off", 32'(ce), 32'd0);
        for (int i = 1; i <= 3; i++) tick(0, 0, 1, 1, '0);
        check("c_err_sticky", 32'(err), 32'd1);
        tick(1, 0, 0, 0, W'(3));
        check("c_err_clear", 32'(err), 32'd0);
        tick(0, 1, 0, 0, '0);
        check("c_abort_idle", 32'(busy), 32'd0);

        // Abort coincident with data_valid.
        tick(1, 0, 0, 0, W'(5));
        tick(0, 0, 1, 0, '0);
        tick(0, 1, 1, 0, '0);
        check("d_idle", 32'(busy), 32'd0);
        check("d_no_done", 32'(done), 32'd0);
        check("d_cnt", 32'(byte_cnt), 32'd1);

        // Restart while busy is ignored; reset in drain; single-byte job.
        tick(1, 0, 0, 0, W'(3));
        tick(1, 0, 1, 0, W'(9));
        tick(0, 0, 1, 0, '0);
        check("e_last", 32'(m_last), 32'd1);
        check("e_cnt2", 32'(byte_cnt), 32'd2);
        tick(0, 0, 1, 0, '0);
        tick(0, 0, 0, 1, '0);
        tick(0, 0, 0, 0, '0);
        rst = 1'b0;
        model_reset();
        #1;
        check_outputs();
        check("e_async_ce", 32'(ce), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(1, 0, 0, 0, W'(1));
        check("e_len1_last", 32'(m_last), 32'd1);
        check("e_len1_ce", 32'(ce), 32'd1);
        tick(0, 0, 1, 0, '0);
        tick(0, 0, 0, 1, '0);
        for (int i = 1; i <= 3; i++) tick(0, 0, 0, 0, '0);
        tick(0, 0, 0, 0, '0);
        check("e_done", 32'(done), 32'd1);
        check("e_cnt1", 32'(byte_cnt), 32'd1);
        tick(0, 0, 0, 0, '0);

        // Randomized jobs with varying data rate, empty timing, aborts and stray starts.
        for (int j = 0; j < 150; j++) begin
            int dv_pct;
            case ($urandom_range(0, 3))
                0:       dv_pct = 90;
                1:       dv_pct = 50;
                2:       dv_pct = 20;
                default: dv_pct = 0;
            endcase
            tick(1, ($urandom_range(0, 9) == 0), 0, 0, W'($urandom_range(0, 10)));
            for (int c = 0; c < 60 && e_busy; c++) begin
                tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 59) == 0),
                     ($urandom_range(0, 99) < dv_pct), ($urandom_range(0, 99) < 30),
                     W'($urandom_range(0, 10)));
            end
            if (e_busy) tick(0, 1, 0, 0, '0);
            tick(0, 0, ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), '0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
